mem_port_arbiter: RTL

// Shares the single memory port (RRdy/RVld/RAddr/RWData/RWEn/RData) between the core's

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between a read-only fetch requester and a
// read/write data requester, with round-robin arbitration and a read-response timeout.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              RRdy,
    output logic [ADDR_W-1:0] RAddr,
    output logic [31:0]       RWData,
    output logic              RWEn,
    input  logic              RVld,
    input  logic [31:0]       RData,
    output logic [2:0]        o_dbg_state
);

    // Handshake: a requester raises req with stable addr/data and holds it until its
    // done pulse; done, rdata and err are valid together for that single cycle.

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t              r_state, w_state;
    logic                r_owner, w_owner;
    logic                r_last_owner, w_last_owner;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [ADDR_W-1:0]   r_raddr, w_raddr;
    logic [31:0]         r_rwdata, w_rwdata;
    logic                r_rrdy, w_rrdy;
    logic                r_rwen, w_rwen;
    logic                r_i_done, w_i_done;
    logic                r_d_done, w_d_done;
    logic [31:0]         r_i_rdata, w_i_rdata;
    logic [31:0]         r_d_rdata, w_d_rdata;
    logic                r_i_err, w_i_err;
    logic                r_d_err, w_d_err;
    logic                w_grant_d;
    logic                w_load;
    logic [31:0]         w_load_data;
    logic                w_load_err;

    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_owner = r_last_owner;
        w_cnt        = r_cnt;
        w_raddr      = r_raddr;
        w_rwdata     = r_rwdata;
        w_i_rdata    = r_i_rdata;
        w_d_rdata    = r_d_rdata;
        w_i_err      = r_i_err;
        w_d_err      = r_d_err;
        w_grant_d    = 1'b0;
        w_load       = 1'b0;
        w_load_data  = 32'd0;
        w_load_err   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // On a tie, serve the port that was not served last.
                    w_grant_d    = d_req && (!i_req || (r_last_owner == OWN_I));
                    w_owner      = w_grant_d;
                    w_last_owner = w_grant_d;
                    if (w_grant_d) begin
                        w_raddr  = d_addr;
                        w_rwdata = d_wdata;
                        w_state  = d_we ? ST_WR : ST_RD_ISSUE;
                    end else begin
                        w_raddr  = i_addr;
                        w_state  = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                w_state = ST_RD_WAIT;
                w_cnt   = CNT_W'(1);
            end
            ST_RD_WAIT: begin
                if (RVld) begin
                    w_load      = 1'b1;
                    w_load_data = RData;
                    w_state     = ST_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
                    w_load     = 1'b1;
                    w_load_err = 1'b1;
                    w_state    = ST_RESP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_WR: begin
                w_load  = 1'b1;
                w_state = ST_RESP;
            end
            ST_RESP: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
        endcase

        if (w_load) begin
            if (r_owner == OWN_D) begin
                w_d_rdata = w_load_data;
                w_d_err   = w_load_err;
            end else begin
                w_i_rdata = w_load_data;
                w_i_err   = w_load_err;
            end
        end

        // Strobes and done are decoded from the next state so they appear as registers.
        w_rrdy   = (w_state == ST_RD_ISSUE);
        w_rwen   = (w_state == ST_WR);
        w_i_done = (w_state == ST_RESP) && (r_owner == OWN_I);
        w_d_done = (w_state == ST_RESP) && (r_owner == OWN_D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_D;
            r_cnt        <= '0;
            r_raddr      <= '0;
            r_rwdata     <= '0;
            r_rrdy       <= 1'b0;
            r_rwen       <= 1'b0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_err      <= 1'b0;
            r_d_err      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_owner <= w_last_owner;
            r_cnt        <= w_cnt;
            r_raddr      <= w_raddr;
            r_rwdata     <= w_rwdata;
            r_rrdy       <= w_rrdy;
            r_rwen       <= w_rwen;
            r_i_done     <= w_i_done;
            r_d_done     <= w_d_done;
            r_i_rdata    <= w_i_rdata;
            r_d_rdata    <= w_d_rdata;
            r_i_err      <= w_i_err;
            r_d_err      <= w_d_err;
        end
    end

    assign i_done      = r_i_done;
    assign i_rdata     = r_i_rdata;
    assign i_err       = r_i_err;
    assign d_done      = r_d_done;
    assign d_rdata     = r_d_rdata;
    assign d_err       = r_d_err;
    assign RRdy        = r_rrdy;
    assign RWEn        = r_rwen;
    assign RAddr       = r_raddr;
    assign RWData      = r_rwdata;
    assign o_dbg_state = r_state;

endmodule
